// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : State codes, lamp encodings and lamp decode for the
//               intersection controller.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5
    } state_t;

    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    // Anything not explicitly green/yellow shows red on both roads.
    function automatic lamps_t lamp_decode(input state_t s);
        lamps_t l;
        l.ns = c_RED;
        l.ew = c_RED;
        case (s)
            NS_G:    l.ns = c_GRN;
            NS_Y:    l.ns = c_YEL;
            EW_G:    l.ew = c_GRN;
            EW_Y:    l.ew = c_YEL;
            default: ;
        endcase
        return l;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Loadable down-counter with zero-expiry flag.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_intersection_ctrl
// Description : Two-road intersection controller with request-gated NS green.
//               Optional pedestrian request/walk when TRAFFIC_PED_REQ_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sensor_ew,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [2:0] phase
`ifdef TRAFFIC_PED_REQ_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    function automatic logic [CNT_W-1:0] phase_load(input state_t s);
        case (s)
            NS_G, EW_G: phase_load = CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y: phase_load = CNT_W'(YELLOW_CYC - 1);
            default:    phase_load = CNT_W'(ALLRED_CYC - 1);
        endcase
    endfunction

    state_t           r_state;
    logic             r_req;
    state_t           w_next;
    logic             w_illegal;
    logic             w_expired;
    logic             w_pending;
    logic             w_advance;
    logic             w_enter_ew;
    logic [CNT_W-1:0] w_load_val;
    lamps_t           w_lamps;

`ifdef TRAFFIC_PED_REQ_EN
    logic r_ped;
    assign w_pending = r_req | r_ped;
`else
    assign w_pending = r_req;
`endif

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            NS_G:    w_next = NS_Y;
            NS_Y:    w_next = AR1;
            AR1:     w_next = EW_G;
            EW_G:    w_next = EW_Y;
            EW_Y:    w_next = AR2;
            AR2:     w_next = NS_G;
            default: begin
                w_next    = AR1;
                w_illegal = 1'b1;
            end
        endcase
    end

    // NS green only yields once its minimum time is up and someone is waiting.
    assign w_advance  = w_illegal |
                        (enable & w_expired & ((r_state != NS_G) | w_pending));
    assign w_enter_ew = w_advance & (w_next == EW_G);
    assign w_load_val = phase_load(w_next);
    assign w_lamps    = lamp_decode(w_next);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(ALLRED_CYC - 1))
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_advance),
        .load_val (w_load_val),
        .dec      (enable),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= AR2;
            r_req    <= 1'b0;
            light_ns <= c_RED;
            light_ew <= c_RED;
            phase    <= AR2;
`ifdef TRAFFIC_PED_REQ_EN
            r_ped    <= 1'b0;
            walk     <= 1'b0;
`endif
        end else begin
            if (w_advance) begin
                r_state  <= w_next;
                light_ns <= w_lamps.ns;
                light_ew <= w_lamps.ew;
                phase    <= w_next;
            end
            // Entry to EW_G serves the request, so it wins over a new arrival.
            r_req <= w_enter_ew ? 1'b0 : (r_req | sensor_ew);
`ifdef TRAFFIC_PED_REQ_EN
            r_ped <= w_enter_ew ? 1'b0 : (r_ped | ped_req);
            if (w_advance) begin
                walk <= w_enter_ew & r_ped;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_intersection_ctrl
// Description : Directed self-checking bench with a phase/elapsed-time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_intersection_ctrl;

    localparam int c_G = 20;
    localparam int c_Y = 4;
    localparam int c_A = 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sensor_ew;
    logic       ped_req;
    logic       walk_obs;
    logic [2:0] light_ns;
    logic [2:0] light_ew;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    traffic_intersection_ctrl #(
        .CNT_W      (8),
        .GREEN_CYC  (c_G),
        .YELLOW_CYC (c_Y),
        .ALLRED_CYC (c_A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sensor_ew (sensor_ew),
        .light_ns  (light_ns),
        .light_ew  (light_ew),
        .phase     (phase)
`ifdef TRAFFIC_PED_REQ_EN
        ,
        .ped_req   (ped_req),
        .walk      (walk_obs)
`endif
    );

`ifndef TRAFFIC_PED_REQ_EN
    assign walk_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase index, enabled cycles already spent in it, request flags.
    int m_st = 5;
    int m_el = 0;
    bit m_req = 0, m_ped = 0, m_walk = 0, m_go, m_enter_ew;
    int ns_tbl [6] = '{1, 2, 4, 4, 4, 4};
    int ew_tbl [6] = '{4, 4, 4, 1, 2, 4};

    function automatic int m_len(input int s);
        if (s == 0 || s == 3) return c_G;
        if (s == 1 || s == 4) return c_Y;
        return c_A;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 5; m_el = 0; m_req = 0; m_ped = 0; m_walk = 0;
        end else begin
            m_go = 1'b0;
            if (enable) begin
                if (m_el == m_len(m_st) - 1)
                    m_go = (m_st != 0) || m_req || m_ped;
                else
                    m_el = m_el + 1;
            end
            m_enter_ew = m_go && (m_st == 2);
            if (m_go) begin
                m_walk = m_enter_ew && m_ped;
                m_st   = (m_st + 1) % 6;
                m_el   = 0;
            end
            if (m_enter_ew) begin
                m_req = 0; m_ped = 0;
            end else begin
                m_req = m_req | sensor_ew;
`ifdef TRAFFIC_PED_REQ_EN
                m_ped = m_ped | ped_req;
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            chk("model_phase", 32'(phase), 32'(m_st));
            chk("model_light_ns", 32'(light_ns), 32'(ns_tbl[m_st]));
            chk("model_light_ew", 32'(light_ew), 32'(ew_tbl[m_st]));
            chk("model_walk", 32'(walk_obs), 32'(m_walk));
            chk("both_roads_moving", 32'((light_ns != 3'b100) && (light_ew != 3'b100)), 0);
        end
    end

    task automatic wait_phase(input int p, input int budget);
        int k = 0;
        @(negedge clk);
        while (phase !== 3'(p) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (phase !== 3'(p)) chk("wait_phase_timeout", 32'(phase), 32'(p));
    endtask

    task automatic count_run(input int p, output int n);
        n = (phase === 3'(p)) ? 1 : 0;
        for (int i = 0; i < 200 && n > 0; i++) begin
            @(negedge clk);
            if (phase === 3'(p)) n++;
            else break;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
    endtask

    task automatic pulse_sensor();
        @(posedge clk); #2 sensor_ew = 1'b1;
        @(posedge clk); #2 sensor_ew = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        int run_exp [6] = '{c_G, c_Y, c_A, c_G, c_Y, c_A};
        reset = 1'b0; enable = 1'b1; sensor_ew = 1'b0; ped_req = 1'b0;
        #1 reset = 1'b1;
        started = 1'b1;

        // Reset state and release sequence
        repeat (3) @(negedge clk);
        chk("rst_phase", 32'(phase), 5);
        chk("rst_ns", 32'(light_ns), 4);
        chk("rst_ew", 32'(light_ew), 4);
        chk("rst_walk", 32'(walk_obs), 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("rel0_ns", 32'(light_ns), 4);
        chk("rel0_ew", 32'(light_ew), 4);
        @(negedge clk);
        chk("rel1_ns", 32'(light_ns), 4);
        @(negedge clk);
        chk("rel2_ns", 32'(light_ns), 1);
        chk("rel2_phase", 32'(phase), 0);

        // No request: NS green holds
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (light_ns !== 3'b001 || phase !== 3'd0) bad++;
        end
        chk("idle_bad_cycles", 32'(bad), 0);

        // Full cycle triggered by a short sensor pulse early in NS_G
        pulse_reset();
        wait_phase(0, 20);
        fork
            begin
                repeat (4) @(posedge clk);
                #2 sensor_ew = 1'b1;
                @(posedge clk); #2 sensor_ew = 1'b0;
            end
        join_none
        for (int p = 0; p < 6; p++) begin
            count_run(p, n);
            chk($sformatf("run_len_phase%0d", p), 32'(n), 32'(run_exp[p]));
        end
        chk("run_back_to_nsg", 32'(phase), 0);

        // Enable low during EW_Y freezes everything
        pulse_sensor();
        wait_phase(4, 100);
        enable = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (phase !== 3'd4 || light_ns !== 3'b100 || light_ew !== 3'b010) bad++;
        end
        chk("freeze_bad_cycles", 32'(bad), 0);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (phase === 3'd4) n++;
            else break;
        end
        chk("yellow_remaining", 32'(n), 3);
        chk("after_yellow_phase", 32'(phase), 5);

        // Reset in the middle of EW_G
        pulse_sensor();
        wait_phase(3, 100);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk("midrst_ns", 32'(light_ns), 4);
        chk("midrst_ew", 32'(light_ew), 4);
        chk("midrst_phase", 32'(phase), 5);
        @(posedge clk); #2 reset = 1'b0;
        wait_phase(0, 10);
        chk("midrst_recover_ns", 32'(light_ns), 1);

`ifdef TRAFFIC_PED_REQ_EN
        // Pedestrian request alone gives a walk for the whole EW green
        @(posedge clk); #2 ped_req = 1'b1;
        @(posedge clk); #2 ped_req = 1'b0;
        wait_phase(3, 100);
        n = (walk_obs === 1'b1) ? 1 : 0;
        repeat (59) begin
            @(negedge clk);
            if (walk_obs === 1'b1) n++;
        end
        chk("walk_cycles", 32'(n), 32'(c_G));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: phase timer width in bits.
REQ-002 SHALL have parameter GREEN_CYC, default 20: green phase length in cycles; legal range 1..2^CNT_W.
REQ-003 SHALL have parameter YELLOW_CYC, default 4: yellow phase length in cycles; legal range 1..2^CNT_W.
REQ-004 SHALL have parameter ALLRED_CYC, default 2: all-red clearance length in cycles; legal range 1..2^CNT_W.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: timer and FSM advance only when high.
REQ-008 SHALL have port sensor_ew, input, 1 bit: vehicle waiting on the east-west road.
REQ-009 SHALL have port light_ns, output, 3 bits: north-south lamps, encoded {Red, Yellow, Green}.
REQ-010 SHALL have port light_ew, output, 3 bits: east-west lamps, same encoding as light_ns.
REQ-011 SHALL have port phase, output, 3 bits: current FSM state code.

Function
REQ-012 SHALL implement a Moore FSM with states NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5; codes 6 and 7 are illegal.
REQ-013 SHALL drive lamps as: NS_G ns=001 ew=100; NS_Y ns=010 ew=100; AR1/AR2 both 100; EW_G ns=100 ew=001; EW_Y ns=100 ew=010.
REQ-014 SHALL load the down-counter with (phase length - 1) on entry to each state; the count decrements once per enable-high cycle.
REQ-015 SHALL make each state last exactly its length in enabled cycles: NS_G/EW_G=GREEN_CYC, NS_Y/EW_Y=YELLOW_CYC, AR1/AR2=ALLRED_CYC.
REQ-016 SHALL hold NS_G with the timer at 0 until a request is pending, then go to NS_Y on the next enabled edge (request-gated minimum green).
REQ-017 SHALL latch sensor_ew into a sticky request flag in any state; the flag clears on entry to EW_G.
REQ-018 SHALL give sensor_ew asserted on the same edge as entry to EW_G the clear priority: the request is dropped.
REQ-019 SHALL advance unconditionally on timer expiry: NS_Y->AR1->EW_G->EW_Y->AR2->NS_G.
REQ-020 SHALL freeze state, timer and request flag while enable=0, except that the request flag still latches sensor_ew.
REQ-021 SHALL force AR1, with the timer loaded for ALLRED_CYC, from an illegal state code, so both roads show red.
REQ-022 SHALL never drive green or yellow on both roads in the same cycle.

Reset
REQ-023 SHALL, on reset asserted, asynchronously set state AR2, the timer to ALLRED_CYC-1 and the request flag to 0.
REQ-024 SHALL drive light_ns=100, light_ew=100 and phase=5 from reset assertion.
REQ-025 SHALL, after reset deasserts, sequence AR2 -> NS_G after ALLRED_CYC enabled cycles.
REQ-026 SHALL, on reset asserted mid-phase, abandon the phase immediately; no yellow is shown.

Configuration
REQ-027 SHALL, with TRAFFIC_PED_REQ_EN defined, add input ped_req (1 bit) and output walk (1 bit, reset 0).
REQ-028 SHALL, with TRAFFIC_PED_REQ_EN defined, make ped_req latch a sticky flag with the same semantics as sensor_ew.
REQ-029 SHALL, with TRAFFIC_PED_REQ_EN defined, treat the ped_req flag as a request for REQ-016 and clear it on entry to EW_G.
REQ-030 SHALL, with TRAFFIC_PED_REQ_EN defined, assert walk only during EW_G when that EW_G was entered with the ped flag set.
REQ-031 SHALL, without TRAFFIC_PED_REQ_EN, have no ped_req or walk ports and behave as REQ-001..026.

Structure
REQ-032 SHALL place the state codes, the lamp encodings (RED=100, YEL=010, GRN=001) and a lamp-decode function in package traffic_pkg.
REQ-033 SHALL place the loadable down-counter with expiry flag in sub-module phase_timer, parameterised by CNT_W.

Verification
REQ-034 SHALL test: reset pulse, release -> lamps 100/100 for 2 cycles, then ns=001.
REQ-035 SHALL test: no sensor for 100 cycles -> ns stays 001 and phase=0 throughout.
REQ-036 SHALL test: a 1-cycle sensor_ew pulse at cycle 5 of NS_G -> NS_G ends at cycle 20, then 4 cycles NS_Y, 2 cycles AR1, 20 cycles EW_G, 4 cycles EW_Y, 2 cycles AR2, back to NS_G.
REQ-037 SHALL test: enable low for 10 cycles during EW_Y -> phase and lamps are unchanged; the remaining yellow completes after enable is restored.
REQ-038 SHALL test: reset asserted in EW_G -> lamps 100/100 in the same cycle and phase=5.
REQ-039 SHALL test, with TRAFFIC_PED_REQ_EN: a ped_req pulse with sensor_ew low -> walk=1 for exactly GREEN_CYC cycles of EW_G; with the macro off, a build without those ports passes REQ-034..038.
